// File: rtl/sprite_attr_reader_pkg.sv
// Shared definitions for the sprite attribute reader.
// Holds the attribute word field positions, the scan FSM encoding, the
// table/line-list record types and the default slot count and sprite size.
package sprite_attr_reader_pkg;

    localparam int unsigned NUM_SLOTS           = 8;
    localparam int unsigned SPRITE_SIZE_DEFAULT = 32;

    // Attribute word layout; bits [30:26] are reserved and never stored.
    localparam int unsigned ATTR_EN_BIT  = 31;
    localparam int unsigned ATTR_X_MSB   = 25;
    localparam int unsigned ATTR_X_LSB   = 16;
    localparam int unsigned ATTR_Y_MSB   = 15;
    localparam int unsigned ATTR_Y_LSB   = 6;
    localparam int unsigned ATTR_ROW_MSB = 5;
    localparam int unsigned ATTR_ROW_LSB = 3;
    localparam int unsigned ATTR_COL_MSB = 2;
    localparam int unsigned ATTR_COL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        READY = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       en;
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic [2:0] rom_row;
        logic [2:0] rom_col;
    } sprite_attr_t;

    // One captured sprite for the current line; dy is frozen at scan time.
    typedef struct packed {
        logic [2:0] slot;
        logic [9:0] pos_x;
        logic [4:0] dy;
        logic [2:0] rom_row;
        logic [2:0] rom_col;
    } line_entry_t;

    function automatic sprite_attr_t unpack_attr(input logic [31:0] word);
        sprite_attr_t a;
        a.en      = word[ATTR_EN_BIT];
        a.pos_x   = word[ATTR_X_MSB:ATTR_X_LSB];
        a.pos_y   = word[ATTR_Y_MSB:ATTR_Y_LSB];
        a.rom_row = word[ATTR_ROW_MSB:ATTR_ROW_LSB];
        a.rom_col = word[ATTR_COL_MSB:ATTR_COL_LSB];
        return a;
    endfunction

endpackage

// File: rtl/sprite_attr_reader_if.sv
// Attribute write bus for the sprite attribute table.
//   we   - write strobe
//   addr - slot index 0..7
//   dina - packed attribute word
interface sprite_attr_reader_if;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] dina;

    modport master (output we, output addr, output dina);
    modport slave  (input we, input addr, input dina);
endinterface

// File: rtl/sprite_span_cmp.sv
// Checks whether value lies in [base, base + SPAN) using 11-bit arithmetic so
// neither the subtraction nor the upper bound can wrap.
//   value   - coordinate under test
//   base    - sprite origin on that axis
//   in_span - value is inside the sprite box on this axis
//   offset  - value - base, low 5 bits (meaningful only when in_span)
module sprite_span_cmp #(
    parameter int unsigned SPAN = 32
) (
    input  logic [9:0] value,
    input  logic [9:0] base,
    output logic       in_span,
    output logic [4:0] offset
);

    logic [10:0] diff;

    assign diff    = {1'b0, value} - {1'b0, base};
    assign in_span = (value >= base) && (diff < 11'(SPAN));
    assign offset  = diff[4:0];

endmodule

// File: rtl/sprite_attr_reader.sv
// Sprite attribute reader: keeps an 8-slot attribute table, scans it during
// horizontal blanking to build the list of sprites on the next scanline, then
// resolves the front-most sprite per pixel and forms its ROM address.
//   clk, reset        - clock, synchronous active-high reset
//   attr_bus          - attribute table write port (we/addr/dina)
//   line_start        - pulse at start of horizontal blanking, starts a scan
//   h_cnt, v_cnt      - current pixel column / row
//   video_on          - active display region
//   collision_clr     - clears the sticky collision flag
//   sprite_hit        - an enabled sprite box covers the pixel (registered)
//   sprite_id         - slot of the winning sprite
//   rom_addr          - {rom_row, rom_col, dy, dx}
//   line_overflow     - more than MAX_PER_LINE sprites matched this line
//   collision         - sticky overlap flag
// Optional feature: define SPRITE_COLLISION_EN to enable collision detection;
// otherwise collision is tied to 0 and collision_clr is ignored.
module sprite_attr_reader
    import sprite_attr_reader_pkg::*;
#(
    parameter int unsigned SPRITE_SIZE  = SPRITE_SIZE_DEFAULT,
    parameter int unsigned MAX_PER_LINE = 4,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_attr_reader_if.slave  attr_bus,
    input  logic                 line_start,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic                 video_on,
    input  logic                 collision_clr,
    output logic                 sprite_hit,
    output logic [2:0]           sprite_id,
    output logic [15:0]          rom_addr,
    output logic                 line_overflow,
    output logic                 collision
);

    localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

    sprite_attr_t     table_q [NUM_SLOTS];
    scan_state_e      state_q;
    logic [2:0]       scan_idx_q;
    logic [9:0]       line_y_q;
    logic [CNT_W-1:0] list_cnt_q;
    line_entry_t      list_q [MAX_PER_LINE];

    // ------------------------------------------------------------------
    // Attribute table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                table_q[i] <= '0;
            end
        end else if (attr_bus.we) begin
            table_q[attr_bus.addr] <= unpack_attr(attr_bus.dina);
        end
    end

    // ------------------------------------------------------------------
    // Line scan: one slot per cycle against the latched target line
    // ------------------------------------------------------------------
    sprite_attr_t scan_attr;
    logic         y_in_span;
    logic [4:0]   y_offset;
    logic         y_match;
    logic [9:0]   line_y_next;

    assign scan_attr   = table_q[scan_idx_q];
    assign y_match     = scan_attr.en && y_in_span;
    assign line_y_next = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;

    sprite_span_cmp #(
        .SPAN (SPRITE_SIZE)
    ) u_y_cmp (
        .value   (line_y_q),
        .base    (scan_attr.pos_y),
        .in_span (y_in_span),
        .offset  (y_offset)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            scan_idx_q    <= '0;
            line_y_q      <= '0;
            list_cnt_q    <= '0;
            line_overflow <= 1'b0;
            for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
                list_q[i] <= '0;
            end
        end else if (line_start) begin
            state_q       <= SCAN;
            scan_idx_q    <= '0;
            line_y_q      <= line_y_next;
            list_cnt_q    <= '0;
            line_overflow <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                SCAN: begin
                    if (y_match) begin
                        if (list_cnt_q < CNT_W'(MAX_PER_LINE)) begin
                            for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
                                if (CNT_W'(i) == list_cnt_q) begin
                                    list_q[i] <= '{slot:    scan_idx_q,
                                                   pos_x:   scan_attr.pos_x,
                                                   dy:      y_offset,
                                                   rom_row: scan_attr.rom_row,
                                                   rom_col: scan_attr.rom_col};
                                end
                            end
                            list_cnt_q <= list_cnt_q + CNT_W'(1);
                        end else begin
                            line_overflow <= 1'b1;
                        end
                    end
                    scan_idx_q <= scan_idx_q + 3'd1;
                    if (scan_idx_q == 3'(NUM_SLOTS - 1)) begin
                        state_q <= READY;
                    end
                end
                READY: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel stage: per-entry x test, lowest list index wins
    // ------------------------------------------------------------------
    logic [MAX_PER_LINE-1:0] x_in_span;
    logic [MAX_PER_LINE-1:0] entry_hit;
    logic [4:0]              x_offset [MAX_PER_LINE];

    for (genvar g = 0; g < int'(MAX_PER_LINE); g++) begin : g_xcmp
        sprite_span_cmp #(
            .SPAN (SPRITE_SIZE)
        ) u_x_cmp (
            .value   (h_cnt),
            .base    (list_q[g].pos_x),
            .in_span (x_in_span[g]),
            .offset  (x_offset[g])
        );
        // Stale entries beyond the current count must not hit.
        assign entry_hit[g] = x_in_span[g] && (CNT_W'(g) < list_cnt_q);
    end

    logic        hit_any;
    logic        multi_hit;
    line_entry_t win_entry;
    logic [4:0]  win_dx;
    logic        pixel_active;

    assign pixel_active = (state_q == READY) && video_on;

    always_comb begin
        hit_any   = 1'b0;
        multi_hit = 1'b0;
        win_entry = '0;
        win_dx    = '0;
        for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
            if (entry_hit[i]) begin
                if (hit_any) begin
                    multi_hit = 1'b1;
                end else begin
                    win_entry = list_q[i];
                    win_dx    = x_offset[i];
                end
                hit_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !pixel_active) begin
            sprite_hit <= 1'b0;
            sprite_id  <= '0;
            rom_addr   <= '0;
        end else begin
            sprite_hit <= hit_any;
            sprite_id  <= win_entry.slot;
            rom_addr   <= {win_entry.rom_row, win_entry.rom_col, win_entry.dy, win_dx};
        end
    end

`ifdef SPRITE_COLLISION_EN
    // Clear takes priority over a set in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || collision_clr) begin
            collision <= 1'b0;
        end else if (pixel_active && multi_hit) begin
            collision <= 1'b1;
        end
    end
`else
    logic unused_collision;
    assign unused_collision = collision_clr ^ multi_hit;
    assign collision        = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_attr_reader.sv
module tb_sprite_attr_reader;

    localparam int SIZE = 32;
    localparam int MAXL = 4;
    localparam int VT   = 525;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        video_on;
    logic        collision_clr;
    logic        sprite_hit;
    logic [2:0]  sprite_id;
    logic [15:0] rom_addr;
    logic        line_overflow;
    logic        collision;

    sprite_attr_reader_if bus ();

    sprite_attr_reader #(
        .SPRITE_SIZE  (SIZE),
        .MAX_PER_LINE (MAXL),
        .V_TOTAL      (VT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .attr_bus      (bus),
        .line_start    (line_start),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt),
        .video_on      (video_on),
        .collision_clr (collision_clr),
        .sprite_hit    (sprite_hit),
        .sprite_id     (sprite_id),
        .rom_addr      (rom_addr),
        .line_overflow (line_overflow),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

`ifdef SPRITE_COLLISION_EN
    localparam bit COLL_ON = 1'b1;
`else
    localparam bit COLL_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_en[8], m_x[8], m_y[8], m_row[8], m_col[8];
    int l_slot[$], l_x[$], l_dy[$], l_row[$], l_col[$];
    int m_since = -1;
    bit m_ready = 0;
    int m_line_y = 0;
    bit m_ovf = 0;
    bit m_coll = 0;
    bit e_hit = 0;
    int e_id = 0;
    int e_addr = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int k = 0; k < 8; k++) m_en[k] = 0;
                l_slot.delete(); l_x.delete(); l_dy.delete(); l_row.delete(); l_col.delete();
                m_since = -1; m_ready = 0; m_ovf = 0; m_coll = 0;
                e_hit = 0; e_id = 0; e_addr = 0;
            end else begin
                int hits;
                int h;
                hits = 0; e_hit = 0; e_id = 0; e_addr = 0;
                h = int'(h_cnt);
                if (m_ready && video_on) begin
                    for (int k = 0; k < l_slot.size(); k++) begin
                        if (h >= l_x[k] && h < l_x[k] + SIZE) begin
                            hits++;
                            if (hits == 1) begin
                                e_hit  = 1;
                                e_id   = l_slot[k];
                                e_addr = l_row[k] * 8192 + l_col[k] * 1024 + l_dy[k] * 32
                                         + (h - l_x[k]);
                            end
                        end
                    end
                end
                if (!COLL_ON || collision_clr) m_coll = 0;
                else if (hits >= 2) m_coll = 1;

                if (line_start) begin
                    m_line_y = (int'(v_cnt) == VT - 1) ? 0 : int'(v_cnt) + 1;
                    l_slot.delete(); l_x.delete(); l_dy.delete(); l_row.delete(); l_col.delete();
                    m_ovf = 0; m_ready = 0; m_since = 0;
                end else if (m_since >= 0 && m_since < 8) begin
                    int k;
                    k = m_since;
                    if (m_en[k] != 0 && m_line_y >= m_y[k] && m_line_y - m_y[k] < SIZE) begin
                        if (l_slot.size() < MAXL) begin
                            l_slot.push_back(k); l_x.push_back(m_x[k]);
                            l_dy.push_back(m_line_y - m_y[k]);
                            l_row.push_back(m_row[k]); l_col.push_back(m_col[k]);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    m_since++;
                    if (m_since == 8) m_ready = 1;
                end

                if (bus.we) begin
                    int a;
                    logic [31:0] d;
                    a = int'(bus.addr);
                    d = bus.dina;
                    m_en[a]  = int'(d[31]);
                    m_x[a]   = int'(d[25:16]);
                    m_y[a]   = int'(d[15:6]);
                    m_row[a] = int'(d[5:3]);
                    m_col[a] = int'(d[2:0]);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("hit",      32'(sprite_hit),    32'(e_hit));
                check("id",       32'(sprite_id),     32'(e_id));
                check("rom_addr", 32'(rom_addr),      32'(e_addr));
                check("overflow", 32'(line_overflow), 32'(m_ovf));
                check("collision", 32'(collision),    32'(m_coll));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int slot, input int en, input int x, input int y,
                      input int row, input int col);
        logic [31:0] d;
        logic [31:0] xv, yv, rv, cv;
        xv = 32'(x); yv = 32'(y); rv = 32'(row); cv = 32'(col);
        d        = '0;
        d[31]    = (en != 0);
        d[30:26] = 5'h15;  // reserved bits carry junk that must be ignored
        d[25:16] = xv[9:0];
        d[15:6]  = yv[9:0];
        d[5:3]   = rv[2:0];
        d[2:0]   = cv[2:0];
        bus.we   = 1'b1;
        bus.addr = 3'(slot);
        bus.dina = d;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic new_line(input int v);
        v_cnt      = 10'(v);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (8) tick();
    endtask

    task automatic pix(input int h);
        h_cnt = 10'(h);
        tick();
    endtask

    task automatic lit(input string name, input int hit, input int id, input int addr);
        check({name, ".hit"}, 32'(sprite_hit), 32'(hit));
        check({name, ".id"},  32'(sprite_id),  32'(id));
        check({name, ".addr"}, 32'(rom_addr),  32'(addr));
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; h_cnt = '0; v_cnt = '0;
        video_on = 1'b1; collision_clr = 1'b0;
        bus.we = 1'b0; bus.addr = '0; bus.dina = '0;
        tick();
        chk_en = 1;
        tick();
        lit("reset", 0, 0, 0);
        check("reset.ovf", 32'(line_overflow), 32'd0);
        check("reset.coll", 32'(collision), 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: basic hit and address
        wr(0, 1, 80, 400, 0, 2);
        new_line(399);
        pix(85);
        lit("t1", 1, 0, 16'h0805);

        // Test 2: overflow past four entries
        for (int i = 0; i < 6; i++) wr(i, 1, 20 + 100 * i, 100, 1, i);
        new_line(99);
        check("t2.ovf", 32'(line_overflow), 32'd1);
        pix(325);
        lit("t2.s3", 1, 3, 16'h2C05);
        pix(425);
        lit("t2.s4", 0, 0, 0);
        pix(525);
        lit("t2.s5", 0, 0, 0);
        check("t2.ovf_held", 32'(line_overflow), 32'd1);

        // Test 3: two overlapping sprites, lower slot wins
        for (int i = 0; i < 6; i++) wr(i, 0, 0, 0, 0, 0);
        wr(1, 1, 200, 50, 2, 3);
        wr(3, 1, 200, 50, 4, 5);
        new_line(49);
        pix(210);
        lit("t3", 1, 1, 16'h4C0A);
        check("t3.coll", 32'(collision), 32'(COLL_ON));
        pix(0);
        check("t3.coll_sticky", 32'(collision), 32'(COLL_ON));
        collision_clr = 1'b1;
        pix(210);
        check("t3.clr_wins", 32'(collision), 32'd0);
        collision_clr = 1'b0;
        pix(0);
        check("t3.cleared", 32'(collision), 32'd0);

        // Test 4: line wrap, no-wrap y compare, dy/dx edges
        wr(1, 0, 0, 0, 0, 0);
        wr(3, 0, 0, 0, 0, 0);
        wr(0, 1, 10, 0, 0, 0);
        new_line(524);
        pix(10);
        lit("t4.wrap", 1, 0, 0);
        pix(41);
        lit("t4.dx31", 1, 0, 31);
        pix(42);
        lit("t4.dx32", 0, 0, 0);
        wr(0, 0, 0, 0, 0, 0);
        wr(1, 1, 10, 1000, 0, 0);
        new_line(4);
        pix(10);
        lit("t4.y1000", 0, 0, 0);
        wr(1, 1, 10, 100, 0, 0);
        new_line(130);
        pix(12);
        lit("t4.dy31", 1, 1, 994);
        new_line(131);
        pix(12);
        lit("t4.dy32", 0, 0, 0);

        // Test 5: writes during scan cycle 2
        wr(1, 0, 0, 0, 0, 0);
        v_cnt = 10'd199; line_start = 1'b1; tick(); line_start = 1'b0;
        repeat (2) tick();
        wr(7, 1, 50, 200, 0, 0);
        repeat (5) tick();
        pix(55);
        lit("t5.slot7_now", 1, 7, 5);
        v_cnt = 10'd199; line_start = 1'b1; tick(); line_start = 1'b0;
        repeat (2) tick();
        wr(0, 1, 50, 200, 0, 0);
        repeat (5) tick();
        pix(55);
        lit("t5.slot0_late", 1, 7, 5);
        new_line(199);
        pix(55);
        lit("t5.slot0_next", 1, 0, 5);

        // Test 6: reset mid-scan
        v_cnt = 10'd199; line_start = 1'b1; tick(); line_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        lit("t6.reset", 0, 0, 0);
        check("t6.ovf", 32'(line_overflow), 32'd0);
        check("t6.state", 32'(dut.state_q), 32'd0);
        reset = 1'b0;
        new_line(199);
        pix(55);
        lit("t6.no_hit", 0, 0, 0);
        wr(0, 1, 50, 200, 0, 0);
        new_line(199);
        pix(55);
        lit("t6.rewritten", 1, 0, 5);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_attr_reader.md
SPRITE_ATTR_READER -- requirements
Module: sprite_attr_reader

Interface
REQ-001 Parameter SPRITE_SIZE, default 32, sprite width and height in pixels; power of two, 8 to 32.
REQ-002 Parameter MAX_PER_LINE, default 4, number of sprite entries captured per scanline.
REQ-003 Parameter V_TOTAL, default 525, number of scanlines per frame.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we  in  1  attribute write strobe.
REQ-007 addr  in  3  sprite slot index, 0 to 7.
REQ-008 dina  in  32  attribute word: [31] enable, [30:26] reserved, [25:16] pos_x, [15:6] pos_y, [5:3] rom_row, [2:0] rom_col.
REQ-009 line_start  in  1  one-cycle pulse at the start of horizontal blanking.
REQ-010 h_cnt, v_cnt  in  10 each  current pixel column and row.
REQ-011 video_on  in  1  active display region.
REQ-012 sprite_hit  out  1  an opaque sprite box covers the pixel.
REQ-013 sprite_id  out  3  slot of the winning sprite.
REQ-014 rom_addr  out  16  {rom_row, rom_col, dy[4:0], dx[4:0]}.
REQ-015 line_overflow  out  1  more than MAX_PER_LINE sprites matched the current line.
REQ-016 collision  out  1  sticky overlap flag; cleared by collision_clr (in, 1).

Function
REQ-017 The block SHALL hold an 8-entry attribute table; a write with we=1 updates slot addr on the next edge, and reserved bits SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, SCAN and READY; line_start SHALL move any state to SCAN with scan index 0 and an empty line list.
REQ-019 Target line SHALL be line_y = v_cnt+1, wrapping to 0 when v_cnt = V_TOTAL-1, sampled on line_start.
REQ-020 SCAN SHALL examine one slot per cycle, slots 0 to 7, and enter READY after slot 7 (8 cycles).
REQ-021 A slot SHALL match when enable=1, line_y >= pos_y and (line_y - pos_y) < SPRITE_SIZE, using 10-bit unsigned compare with no wrap.
REQ-022 Matching slots SHALL be appended in ascending slot order; a match with the list full SHALL set line_overflow and be discarded.
REQ-023 line_overflow SHALL be held until the next line_start.
REQ-024 A write to a slot not yet scanned SHALL be seen by the current scan; a write to a slot already scanned SHALL take effect on the next line only.
REQ-025 In READY with video_on=1, an entry SHALL hit when h_cnt >= pos_x and h_cnt < pos_x + SPRITE_SIZE, computed at 11 bits with no overflow.
REQ-026 The lowest-index list entry (lowest slot) SHALL win when several entries hit.
REQ-027 Outputs SHALL be registered with 1-cycle latency from h_cnt.
REQ-028 dx SHALL equal h_cnt - pos_x and dy SHALL equal line_y - pos_y at the latched line, zero-extended to 5 bits.
REQ-029 In IDLE or SCAN, or with video_on=0, sprite_hit, sprite_id and rom_addr SHALL be 0.

Reset
REQ-030 reset SHALL force state IDLE, clear all table entries (enable=0), empty the line list, and drive every output to 0, including mid-SCAN and mid-line.

Configuration
REQ-031 When SPRITE_COLLISION_EN is defined, collision SHALL set on any cycle with two or more simultaneous hits, stay set until collision_clr=1, and collision_clr SHALL win over a simultaneous set.
REQ-032 When SPRITE_COLLISION_EN is not defined, collision SHALL be constant 0 and collision_clr SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the attribute field bit positions, the FSM state encoding, and the defaults for NUM_SLOTS=8 and SPRITE_SIZE.
REQ-034 Per-entry range comparison SHALL be a sub-module named sprite_span_cmp, instantiated for both the y match and the x match.

Verification
REQ-035 Test 1: write slot0 = {1, x=80, y=400, row=0, col=2}, v_cnt=399, pulse line_start, h_cnt=85 -> after 1 cycle sprite_hit=1, sprite_id=0, rom_addr={0, 2, 0, 5}.
REQ-036 Test 2: enable slots 0 to 5, all with y=100, v_cnt=99 -> list holds slots 0 to 3, line_overflow=1, and slot 4 never hits.
REQ-037 Test 3: slot1 and slot3 both at x=200, y=50, on line 50, h_cnt=210 -> sprite_id=1; with the macro, collision=1 until collision_clr.
REQ-038 Test 4: v_cnt=524, slot0 y=0 -> matches line 0; a slot at y=1000 on line 5 -> no match.
REQ-039 Test 5: a write to slot7 on scan cycle 2 is seen in the current line; a write to slot0 on scan cycle 2 is seen only on the next line.
REQ-040 Test 6: assert reset during SCAN -> outputs 0 and state IDLE; the next line produces no hits until the table is rewritten.
